// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: PC, imem request/response FIFO, redirect flush.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          INFLIGHT_MAX = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_redirects
`endif
);

  localparam int AW = $clog2(INFLIGHT_MAX);
  localparam int CW = AW + 1;
  localparam int DW = 16;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             pc_q, pc_d;
  logic [31:0]             ent_pc_q   [INFLIGHT_MAX];
  logic [31:0]             ent_pc_d   [INFLIGHT_MAX];
  logic [31:0]             ent_data_q [INFLIGHT_MAX];
  logic [31:0]             ent_data_d [INFLIGHT_MAX];
  logic [INFLIGHT_MAX-1:0] ent_filled_q, ent_filled_d;
  logic [AW-1:0]           head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0]           count_q, count_d, unfilled_q, unfilled_d;
  logic [DW-1:0]           discard_q, discard_d;
  logic                    err_q, err_d;

  logic fifo_full, redirect_run, req_fire, inst_fire, rsp_tracked, fill_now;

  assign fifo_full    = (count_q == CW'(INFLIGHT_MAX));
  assign redirect_run = redirect_valid && (state_q == RUN);
  assign rsp_tracked  = imem_rsp_valid && ((discard_q != '0) || (unfilled_q != '0));
  assign fill_now     = imem_rsp_valid && (discard_q == '0) && (unfilled_q != '0);

  assign imem_req_valid = !reset && (state_q == RUN) && !fifo_full && !redirect_valid;
  assign imem_req_addr  = reset ? RESET_PC : pc_q;
  assign inst_valid     = !reset && ent_filled_q[head_q] && !redirect_valid;
  assign inst_data      = reset ? 32'h0 : ent_data_q[head_q];
  assign inst_pc        = reset ? 32'h0 : ent_pc_q[head_q];
  assign misalign_err   = !reset && err_q;

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign inst_fire = inst_valid && inst_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ent_pc_d     = ent_pc_q;
    ent_data_d   = ent_data_q;
    ent_filled_d = ent_filled_q;
    head_d       = head_q;
    tail_d       = tail_q;
    fill_d       = fill_q;
    count_d      = count_q;
    unfilled_d   = unfilled_q;
    discard_d    = discard_q;
    err_d        = err_q;

    if (redirect_run) begin
      // Everything still owed by imem becomes discard; a response landing now settles one of them.
      pc_d         = redirect_target;
      ent_filled_d = '0;
      head_d       = '0;
      tail_d       = '0;
      fill_d       = '0;
      count_d      = '0;
      unfilled_d   = '0;
      discard_d    = discard_q + DW'(unfilled_q) - DW'(rsp_tracked);
      if (redirect_target[1:0] != 2'b00) begin
        state_d = HALT;
        err_d   = 1'b1;
      end
    end else begin
      if (req_fire) begin
        ent_pc_d[tail_q]     = pc_q;
        ent_filled_d[tail_q] = 1'b0;
        tail_d               = tail_q + 1'b1;
        pc_d                 = pc_q + 32'd4;
      end
      if (imem_rsp_valid && (discard_q != '0)) begin
        discard_d = discard_q - 1'b1;
      end else if (fill_now) begin
        ent_data_d[fill_q]   = imem_rsp_data;
        ent_filled_d[fill_q] = 1'b1;
        fill_d               = fill_q + 1'b1;
      end
      if (inst_fire) begin
        ent_filled_d[head_q] = 1'b0;
        head_d               = head_q + 1'b1;
      end
      count_d    = count_q + CW'(req_fire) - CW'(inst_fire);
      unfilled_d = unfilled_q + CW'(req_fire) - CW'(fill_now);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      ent_filled_q <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      fill_q       <= '0;
      count_q      <= '0;
      unfilled_q   <= '0;
      discard_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ent_filled_q <= ent_filled_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      fill_q       <= fill_d;
      count_q      <= count_d;
      unfilled_q   <= unfilled_d;
      discard_q    <= discard_d;
      err_q        <= err_d;
    end
  end

  // Payload storage is qualified by ent_filled_q, so it needs no reset.
  always_ff @(posedge clock) begin
    ent_pc_q   <= ent_pc_d;
    ent_data_q <= ent_data_d;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d, perf_redirects_q, perf_redirects_d;

  always_comb begin
    perf_fetched_d   = perf_fetched_q + 32'(inst_fire);
    perf_redirects_d = perf_redirects_q + 32'(redirect_run);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched_q   <= '0;
      perf_redirects_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_redirects_q <= perf_redirects_d;
    end
  end

  assign perf_fetched   = reset ? 32'h0 : perf_fetched_q;
  assign perf_redirects = reset ? 32'h0 : perf_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with imem model and instruction scoreboard.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_redirects;
`endif

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(RESET_PC), .INFLIGHT_MAX(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .misalign_err   (misalign_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_redirects (perf_redirects)
`endif
  );

  typedef struct {logic [31:0] addr; int due;} pend_t;
  typedef struct {logic [31:0] pc; logic [31:0] data;} inst_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          lat = 1;
  int          cyc = 0;
  int          req_hs = 0;
  pend_t       pend[$];
  inst_t       exp_q[$];
  logic [31:0] exp_addr = RESET_PC;
  bit          tb_halted = 1'b0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // imem model: in-order responses, sampled by the DUT 'lat' edges after the request edge.
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      #2;
      if (reset) begin
        pend.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end else begin
        if (imem_rsp_valid) void'(pend.pop_front());
        if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem(pend[0].addr);
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = 32'h0;
        end
      end
    end
  end

  // Request tracker and instruction scoreboard, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        exp_addr  = RESET_PC;
        tb_halted = 1'b0;
      end else begin
        if (redirect_valid && !tb_halted) begin
          exp_q.delete();
          exp_addr = redirect_target;
          if (redirect_target[1:0] != 2'b00) tb_halted = 1'b1;
        end
        if (imem_req_valid && imem_req_ready) begin
          chk("req_addr", imem_req_addr, exp_addr);
          pend.push_back('{imem_req_addr, cyc + 1 + lat});
          exp_q.push_back('{imem_req_addr, mem(imem_req_addr)});
          exp_addr = exp_addr + 32'd4;
          req_hs++;
        end
        if (inst_valid && inst_ready) begin
          n_cmp++;
          assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL inst_unexpected observed pc=0x%08h expected=none", inst_pc);
          end
          if (exp_q.size() != 0) begin
            inst_t e;
            e = exp_q.pop_front();
            chk("sb_inst_pc", inst_pc, e.pc);
            chk("sb_inst_data", inst_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  r0;
    bit  found;
    int  cnt;

    // Reset state and first fetch.
    repeat (3) tick();
    @(negedge clock);
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_misalign", misalign_err, 1'b0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("first_req_valid", imem_req_valid, 1'b1);
    chk("first_req_addr", imem_req_addr, RESET_PC);
    tick();
    tick();
    @(negedge clock);
    chk("first_inst_valid", inst_valid, 1'b1);
    chk("first_inst_pc", inst_pc, RESET_PC);
    repeat (12) tick();

    // Decode backpressure: FIFO fills to depth, then fetch resumes at 0x8.
    reset = 1'b1;
    inst_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    r0 = req_hs;
    repeat (10) tick();
    chk("bp_req_count", req_hs - r0, 2);
    @(negedge clock);
    chk("bp_req_valid", imem_req_valid, 1'b0);
    chk("bp_inst_valid", inst_valid, 1'b1);
    chk("bp_inst_pc", inst_pc, 32'h0);
    tick();
    inst_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (imem_req_valid && imem_req_ready) begin
        found = 1'b1;
        chk("bp_resume_addr", imem_req_addr, 32'h8);
      end
    end
    chk("bp_resume_seen", found, 1'b1);

    // Latency 3: redirect with 0x8 and 0xC outstanding.
    tick();
    reset = 1'b1;
    lat = 3;
    repeat (2) tick();
    reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clock);
      if (imem_req_valid && imem_req_ready && imem_req_addr == 32'hC) found = 1'b1;
    end
    chk("rd_req_c_seen", found, 1'b1);
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    @(negedge clock);
    chk("rd_req_masked", imem_req_valid, 1'b0);
    chk("rd_inst_masked", inst_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clock);
    chk("rd_next_req_valid", imem_req_valid, 1'b1);
    chk("rd_next_req_addr", imem_req_addr, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clock);
      if (inst_valid && inst_ready) begin
        found = 1'b1;
        chk("rd_first_pc", inst_pc, 32'h100);
        chk("rd_first_data", inst_data, mem(32'h100));
      end
    end
    chk("rd_first_seen", found, 1'b1);

    // Redirect coinciding with a response and a ready head entry.
    tick();
    reset = 1'b1;
    lat = 1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    @(negedge clock);
    chk("rr_rsp_valid", imem_rsp_valid, 1'b1);
    chk("rr_inst_masked", inst_valid, 1'b0);
    chk("rr_req_masked", imem_req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clock);
    chk("rr_next_req_valid", imem_req_valid, 1'b1);
    chk("rr_next_req_addr", imem_req_addr, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clock);
      if (inst_valid && inst_ready) begin
        found = 1'b1;
        chk("rr_first_pc", inst_pc, 32'h100);
      end
    end
    chk("rr_first_seen", found, 1'b1);

    // Misaligned redirect halts until reset.
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h102;
    tick();
    redirect_valid = 1'b0;
    @(negedge clock);
    chk("ma_err", misalign_err, 1'b1);
    chk("ma_req_valid", imem_req_valid, 1'b0);
    chk("ma_inst_valid", inst_valid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      redirect_valid  = (i == 3);
      redirect_target = 32'h200;
      @(negedge clock);
      chk("halt_err", misalign_err, 1'b1);
      chk("halt_req_valid", imem_req_valid, 1'b0);
      chk("halt_inst_valid", inst_valid, 1'b0);
    end
    tick();
    redirect_valid = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clock);
    chk("ma_rst_err", misalign_err, 1'b0);
    chk("ma_rst_req_valid", imem_req_valid, 1'b1);
    chk("ma_rst_req_addr", imem_req_addr, RESET_PC);

`ifdef FETCH_PERF_CNT_EN
    // Perf counters: five deliveries, two redirects.
    tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60 && cnt < 5; i++) begin
      @(negedge clock);
      if (inst_valid && inst_ready) cnt++;
    end
    chk("perf_deliveries_seen", cnt, 5);
    tick();
    inst_ready      = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    tick();
    redirect_valid = 1'b0;
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h300;
    tick();
    redirect_valid = 1'b0;
    repeat (2) tick();
    @(negedge clock);
    chk("perf_fetched", perf_fetched, 32'd5);
    chk("perf_redirects", perf_redirects, 32'd2);
`else
    cnt = 0;
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
